// File: rtl/pipe64_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// pipe64_pkg : opcodes, IR field positions and memory FSM states
//              shared by the 64-bit pipeline stages.
// Rev 1.0
// ------------------------------------------------------------------
package pipe64_pkg;

  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_ALU    = 8'h01;
  localparam logic [7:0] OP_LOAD   = 8'h02;
  localparam logic [7:0] OP_STORE  = 8'h03;
  localparam logic [7:0] OP_LOADI  = 8'h04;
  localparam logic [7:0] OP_BRANCH = 8'h05;

  localparam int OPC_HI   = 63;
  localparam int OPC_LO   = 56;
  localparam int RD_HI    = 27;
  localparam int RD_LO    = 23;
  localparam int ALUOP_HI = 22;
  localparam int ALUOP_LO = 18;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_REQ  = 1'b1;

  typedef enum logic [1:0] {
    CLS_NOP = 2'd0,
    CLS_REG = 2'd1,
    CLS_MEM = 2'd2
  } op_class_t;

  // Unknown opcodes fall into the NOP class along with NOP and BRANCH.
  function automatic op_class_t op_class(input logic [7:0] op);
    case (op)
      OP_ALU, OP_LOADI:  return CLS_REG;
      OP_LOAD, OP_STORE: return CLS_MEM;
      default:           return CLS_NOP;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_fsm.sv
`default_nettype none
// ------------------------------------------------------------------
// mem_access_fsm : IDLE/REQ sequencing, stall and mem_req generation.
// Optional REQ timeout abort enabled by defining MEM_STAGE_TIMEOUT_EN.
// Rev 1.0
// ------------------------------------------------------------------
module mem_access_fsm
  import pipe64_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_start,
  input  logic i_ack,
  output logic o_stall,
  output logic o_mem_req,
  output logic o_complete,
  output logic o_abort,
  output logic o_mem_err
);

  state_t r_state;
  state_t w_state_nxt;
  logic   w_timeout;
  logic   w_complete;
  logic   w_abort;

  if (TIMEOUT < 1) begin : g_timeout_chk
    $error("TIMEOUT must be at least 1");
  end

  always_comb begin
    w_state_nxt = r_state;
    w_complete  = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) w_state_nxt = ST_REQ;
      end
      ST_REQ: begin
        // An ack arriving on the timeout cycle still completes the access.
        if (i_ack) begin
          w_complete  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_timeout) begin
          w_abort     = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

`ifdef MEM_STAGE_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             r_err;

  // w_cnt_inc counts REQ cycles including the current one.
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_timeout = (r_state == ST_REQ) && (w_cnt_inc == CNT_W'(TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state == ST_IDLE) r_cnt <= '0;
      else                    r_cnt <= w_cnt_inc;
      if (w_abort) r_err <= 1'b1;
    end
  end

  assign o_mem_err = r_err;
`else
  assign w_timeout = 1'b0;
  assign o_mem_err = 1'b0;
`endif

  assign o_stall    = (r_state == ST_REQ);
  assign o_mem_req  = (r_state == ST_REQ);
  assign o_complete = w_complete;
  assign o_abort    = w_abort;

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ------------------------------------------------------------------
// mem_stage : memory-access pipeline stage; loads/stores over req/ack
//             and forwards a writeback record. Timeout: MEM_STAGE_TIMEOUT_EN.
// Rev 1.0
// ------------------------------------------------------------------
module mem_stage
  import pipe64_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] IR,
  input  logic [DATA_W-1:0] addr_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              wb_valid,
  output logic [4:0]        wb_reg,
  output logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] IR_out,
  output logic              mem_err
);

  logic [7:0]        w_opcode;
  logic [4:0]        w_rd;
  logic [4:0]        w_rd_lat;
  op_class_t         w_cls;
  logic              w_stall;
  logic              w_complete;
  logic              w_abort;

  logic [DATA_W-1:0] r_ir_lat;
  logic              r_mem_we;
  logic [DATA_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_wb_valid;
  logic [4:0]        r_wb_reg;
  logic [DATA_W-1:0] r_wb_data;
  logic [DATA_W-1:0] r_ir_out;

  assign w_opcode = IR[OPC_HI:OPC_LO];
  assign w_rd     = IR[RD_HI:RD_LO];
  assign w_rd_lat = r_ir_lat[RD_HI:RD_LO];
  assign w_cls    = op_class(w_opcode);

  mem_access_fsm #(
    .TIMEOUT (TIMEOUT)
  ) u_fsm (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (w_cls == CLS_MEM),
    .i_ack      (mem_ack),
    .o_stall    (w_stall),
    .o_mem_req  (mem_req),
    .o_complete (w_complete),
    .o_abort    (w_abort),
    .o_mem_err  (mem_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ir_lat    <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_wb_valid  <= 1'b0;
      r_wb_reg    <= '0;
      r_wb_data   <= '0;
      r_ir_out    <= '0;
    end else if (!w_stall) begin
      if (w_cls == CLS_MEM) begin
        r_ir_lat    <= IR;
        r_mem_addr  <= addr_in;
        r_mem_wdata <= data_in;
        r_mem_we    <= (w_opcode == OP_STORE);
        r_wb_valid  <= 1'b0;
        r_wb_reg    <= '0;
        r_wb_data   <= '0;
        r_ir_out    <= '0;
      end else begin
        r_wb_valid  <= (w_cls == CLS_REG) && (w_rd != 5'd0);
        r_wb_reg    <= w_rd;
        r_wb_data   <= data_in;
        r_ir_out    <= IR;
      end
    end else if (w_complete) begin
      // r_mem_we still identifies a store on the completing cycle.
      r_mem_we    <= 1'b0;
      r_wb_valid  <= !r_mem_we && (w_rd_lat != 5'd0);
      r_wb_reg    <= w_rd_lat;
      r_wb_data   <= r_mem_we ? '0 : mem_rdata;
      r_ir_out    <= r_ir_lat;
    end else begin
      if (w_abort) r_mem_we <= 1'b0;
      r_wb_valid  <= 1'b0;
      r_wb_reg    <= '0;
      r_wb_data   <= '0;
      r_ir_out    <= '0;
    end
  end

  assign stall     = w_stall;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign wb_valid  = r_wb_valid;
  assign wb_reg    = r_wb_reg;
  assign wb_data   = r_wb_data;
  assign IR_out    = r_ir_out;

endmodule
`default_nettype wire
